// File: rtl/sonar_pkg.sv
// Shared types and 100 MHz default timing constants for the ultrasonic
// ranging scheduler (HC-SR04 / SEN0208 class sensors).
package sonar_pkg;

    // Scheduler FSM states; all share one cycle counter.
    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } sonar_state_t;

    // Defaults for a 100 MHz clock.
    localparam int TRIG_CYCLES  = 1000;       // 10 us trigger pulse
    localparam int ECHO_TIMEOUT = 30000;      // 300 us for the echo to start
    localparam int MAX_ECHO     = 2_320_000;  // 23.2 ms, about 400 cm
    localparam int GUARD_CYCLES = 5_100_000;  // 51 ms between measurements

    localparam int CNT_W  = 23;  // shared FSM counter width
    localparam int RES_W  = 22;  // published echo-width width
    localparam int CHID_W = 3;   // published channel-index width

endpackage

// File: rtl/sonar_rr_pick.sv
// Round-robin channel picker (purely combinational).
// Returns the first channel set in mask strictly after index last, wrapping
// around, so that last itself is chosen only when it is the sole candidate.
//   mask  : channels eligible for selection
//   last  : channel served most recently
//   next  : chosen channel (equals last when nothing is eligible)
//   found : at least one channel is eligible
module sonar_rr_pick #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] next,
    output logic            found
);

    int              idx;
    logic [N_CH-1:0] shifted;

    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // so no path can leave one unassigned and infer a latch.
        next    = last;
        found   = 1'b0;
        idx     = 0;
        shifted = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(last) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            shifted = mask >> idx;
            if (!found && shifted[0]) begin
                found = 1'b1;
                next  = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sonar_scheduler.sv
// Multi-channel ultrasonic ranging scheduler.
// Serves masked channels round-robin: a trigger pulse, a wait for the echo
// to rise, a measurement of the echo width, then a guard holdoff so that
// late reflections cannot leak into the next channel's measurement.
//
// Build option: define SONAR_ECHO_SYNC_EN to pass every echo line through a
// two-flop synchronizer (2 cycles extra latency, same measured widths).
//
// Ports:
//   clock          : system clock (100 MHz for the default constants)
//   reset          : asynchronous, active-high reset
//   enable         : permits new measurement cycles (sampled in IDLE only)
//   ch_mask        : channels that take part in the rotation
//   echo_signal    : raw sensor echo lines
//   trigger_signal : sensor trigger lines, at most one high
//   result_valid   : one-cycle strobe when a result is published
//   result_ch      : channel of the latest result
//   result_cycles  : latest echo width in cycles (0 on timeout)
//   result_oor     : latest result is out of range (timeout or clamp)
//   dist_flat      : last result per channel, channel k at [22k+21:22k]
//   busy           : FSM is not in IDLE
module sonar_scheduler #(
    parameter int N_CH         = 4,
    parameter int TRIG_CYCLES  = sonar_pkg::TRIG_CYCLES,
    parameter int ECHO_TIMEOUT = sonar_pkg::ECHO_TIMEOUT,
    parameter int MAX_ECHO     = sonar_pkg::MAX_ECHO,
    parameter int GUARD_CYCLES = sonar_pkg::GUARD_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [N_CH-1:0]      echo_signal,
    output logic [N_CH-1:0]      trigger_signal,
    output logic                 result_valid,
    output logic [2:0]           result_ch,
    output logic [21:0]          result_cycles,
    output logic                 result_oor,
    output logic [N_CH*22-1:0]   dist_flat,
    output logic                 busy
);

    import sonar_pkg::*;

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Terminal counts: the counter starts at 0 on entry to each timed state.
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CLAMP_LAST   = CNT_W'(MAX_ECHO - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [RES_W-1:0] MAX_RES      = RES_W'(MAX_ECHO);

    sonar_state_t              state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [CH_W-1:0]           cur_ch, ch_next, pick_ch;
    logic                      pick_found;
    logic [N_CH-1:0]           echo_s, echo_prev;
    logic                      echo_cur, echo_rise;
    logic                      pub, pub_oor;
    logic [RES_W-1:0]          pub_cycles;
    logic [N_CH-1:0][RES_W-1:0] dist_q;

`ifdef SONAR_ECHO_SYNC_EN
    logic [N_CH-1:0] echo_meta, echo_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= echo_signal;
            echo_sync <= echo_meta;
        end
    end

    assign echo_s = echo_sync;
`else
    assign echo_s = echo_signal;
`endif

    // echo_prev tracks every line continuously, so an echo that is already
    // high when WAIT_ECHO begins shows no rising edge until it falls and
    // rises again.
    assign echo_cur  = echo_s[cur_ch];
    assign echo_rise = echo_cur & ~echo_prev[cur_ch];

    sonar_rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .mask  (ch_mask),
        .last  (cur_ch),
        .next  (pick_ch),
        .found (pick_found)
    );

    always_comb begin
        state_next     = state;
        cnt_next       = cnt + CNT_W'(1);
        ch_next        = cur_ch;
        pub            = 1'b0;
        pub_oor        = 1'b0;
        pub_cycles     = '0;
        trigger_signal = '0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (enable && pick_found) begin
                    state_next = TRIG;
                    ch_next    = pick_ch;
                end
            end
            TRIG: begin
                trigger_signal[cur_ch] = 1'b1;
                if (cnt == TRIG_LAST) begin
                    state_next = WAIT_ECHO;
                    cnt_next   = '0;
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    // The rise cycle is the first counted echo cycle.
                    state_next = MEASURE;
                    cnt_next   = CNT_W'(1);
                end else if (cnt == TIMEOUT_LAST) begin
                    pub        = 1'b1;
                    pub_oor    = 1'b1;
                    state_next = HOLDOFF;
                    cnt_next   = '0;
                end
            end
            MEASURE: begin
                if (!echo_cur) begin
                    pub        = 1'b1;
                    pub_cycles = cnt[RES_W-1:0];
                    state_next = HOLDOFF;
                    cnt_next   = '0;
                end else if (cnt == CLAMP_LAST) begin
                    // This high cycle brings the count to MAX_ECHO.
                    pub        = 1'b1;
                    pub_oor    = 1'b1;
                    pub_cycles = MAX_RES;
                    state_next = HOLDOFF;
                    cnt_next   = '0;
                end
            end
            HOLDOFF: begin
                if (cnt == GUARD_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            cur_ch        <= CH_W'(N_CH - 1);
            echo_prev     <= '0;
            result_valid  <= 1'b0;
            result_ch     <= '0;
            result_cycles <= '0;
            result_oor    <= 1'b0;
            // NOTE: the per-channel result store is small and visible on a
            // port, so it is reset like any other register.
            dist_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this clock edge.
            state        <= state_next;
            cnt          <= cnt_next;
            cur_ch       <= ch_next;
            echo_prev    <= echo_s;
            result_valid <= pub;
            if (pub) begin
                result_ch      <= CHID_W'(cur_ch);
                result_cycles  <= pub_cycles;
                result_oor     <= pub_oor;
                dist_q[cur_ch] <= pub_cycles;
            end
        end
    end

    assign dist_flat = dist_q;
    assign busy      = (state != IDLE);

endmodule
